// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I-subset control path.
// Opcode constants, the ALU operation class consumed by the ALU control
// decoder, datapath mux encodings and the main FSM state enumeration.
package ctrl_pkg;

  // Instruction opcodes recognised by the main control FSM
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation class handed to the ALU control decoder
  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_e;

  // Second ALU operand select
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

  // Main control FSM states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_e;

  // True for every opcode the datapath knows how to execute
  function automatic logic is_known_opcode(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on mem_ready in the
// memory states and counts retired instructions.
// Optional feature macro: MULTICYCLE_CONTROL_TRAP_EN -- when defined an
// unknown opcode parks the FSM in TRAP (illegal = 1) until reset; otherwise
// the unknown opcode retires as a NOP and illegal stays 0.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  state_e           r_state;
  state_e           w_state_next;
  logic [6:0]       r_opcode;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;

  // State register; an asynchronous reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Capture the opcode in DECODE so MEM_ADDR is immune to IR/bus changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 7'd0;
    end else if (r_state == S_DECODE) begin
      r_opcode <= opcode;
    end
  end

  // Retired-instruction counter, wraps silently at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Next-state decode and retire strobe
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:                w_state_next = S_EXEC_R;
          OP_I:                w_state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:   w_state_next = S_MEM_ADDR;
          OP_BRANCH:           w_state_next = S_BRANCH;
          default: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            w_state_next = S_TRAP;
`else
            // Unknown opcode behaves as a NOP and still counts as retired
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R: w_state_next = S_ALU_WB;
      S_EXEC_I: w_state_next = S_ALU_WB;
      S_ALU_WB: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_MEM_ADDR: begin
        // Only LOAD or STORE reach this state; decide from the latched copy
        w_state_next = (r_opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          w_state_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_BRANCH: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_TRAP: begin
        w_state_next = S_TRAP;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Datapath control decode; every output defaults to 0
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        // PC + 4 computed every cycle; IR and PC commit only with the data
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        alu_src_b = SRCB_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      default: begin
      end
    endcase
  end

`ifdef MULTICYCLE_CONTROL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (CNT_W = 4).
// Table of per-cycle {inputs, expected controls} driven through a scoreboard
// queue, plus hand sequences for reset abort, NOP/trap and counter wrap.
module tb_multicycle_control;

  localparam int CW = 4;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_I      = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_BAD    = 7'b1111111;

  logic          clk;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic          ir_write, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]    alu_src_b, alu_op, pc_source;
  logic [CW-1:0] retired;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .retired(retired), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] act_vec;
  assign act_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                    alu_op, pc_source, illegal};

  function automatic logic [15:0] cv(input logic pcw, pcwc, iord, mr, mw,
                                     irw, m2r, rw, asa,
                                     input logic [1:0] asb, aop, pcs,
                                     input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, asa, asb, aop, pcs, ill};
  endfunction

  logic [15:0] E_F0, E_F1, E_DEC, E_XR, E_XI, E_AWB, E_MA, E_MR, E_MWB;
  logic [15:0] E_MW, E_BR, E_TRAP;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [15:0] exp;
    logic        ret;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0]   exp;
    logic [CW-1:0] ret;
    string         name;
  } sb_t;

  vec_t vecs[32];
  int   n_vec = 0;
  sb_t  sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic add(input logic [6:0] op, input logic mr,
                     input logic [15:0] exp, input logic ret, input string nm);
    vecs[n_vec] = '{op, mr, exp, ret, nm};
    n_vec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_branch();
    opcode    = T_BRANCH;
    mem_ready = 1'b1;
    step();
    step();
    step();
  endtask

  logic [CW-1:0] exp_ret;
  sb_t           sb;
  logic          found;

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b0;

    E_F0   = cv(0,0,0,1,0,0,0,0,0, 2'd1, 2'd0, 2'd0, 0);
    E_F1   = cv(1,0,0,1,0,1,0,0,0, 2'd1, 2'd0, 2'd0, 0);
    E_DEC  = cv(0,0,0,0,0,0,0,0,0, 2'd2, 2'd0, 2'd0, 0);
    E_XR   = cv(0,0,0,0,0,0,0,0,1, 2'd0, 2'd2, 2'd0, 0);
    E_XI   = cv(0,0,0,0,0,0,0,0,1, 2'd2, 2'd2, 2'd0, 0);
    E_AWB  = cv(0,0,0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd0, 0);
    E_MA   = cv(0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, 2'd0, 0);
    E_MR   = cv(0,0,1,1,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    E_MWB  = cv(0,0,0,0,0,0,1,1,0, 2'd0, 2'd0, 2'd0, 0);
    E_MW   = cv(0,0,1,0,1,0,0,0,0, 2'd0, 2'd0, 2'd0, 0);
    E_BR   = cv(0,1,0,0,0,0,0,0,1, 2'd0, 2'd1, 2'd1, 0);
    E_TRAP = cv(0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0, 1);

    // R-type with a fetch stall
    add(T_R,      1'b0, E_F0,  1'b0, "R fetch stall");
    add(T_R,      1'b1, E_F1,  1'b0, "R fetch");
    add(T_R,      1'b1, E_DEC, 1'b0, "R decode");
    add(T_R,      1'b1, E_XR,  1'b0, "R exec");
    add(T_R,      1'b1, E_AWB, 1'b1, "R writeback");
    // I-type
    add(T_I,      1'b1, E_F1,  1'b0, "I fetch");
    add(T_I,      1'b1, E_DEC, 1'b0, "I decode");
    add(T_I,      1'b1, E_XI,  1'b0, "I exec");
    add(T_I,      1'b1, E_AWB, 1'b1, "I writeback");
    // LOAD: live opcode flips to STORE in MEM_ADDR, 3 wait cycles in MEM_READ
    add(T_LOAD,   1'b1, E_F1,  1'b0, "LD fetch");
    add(T_LOAD,   1'b1, E_DEC, 1'b0, "LD decode");
    add(T_STORE,  1'b1, E_MA,  1'b0, "LD addr latched");
    add(T_STORE,  1'b0, E_MR,  1'b0, "LD read wait1");
    add(T_STORE,  1'b0, E_MR,  1'b0, "LD read wait2");
    add(T_STORE,  1'b0, E_MR,  1'b0, "LD read wait3");
    add(T_STORE,  1'b1, E_MR,  1'b0, "LD read done");
    add(T_STORE,  1'b1, E_MWB, 1'b1, "LD writeback");
    // STORE: live opcode flips to LOAD in MEM_ADDR, one wait cycle
    add(T_STORE,  1'b1, E_F1,  1'b0, "ST fetch");
    add(T_STORE,  1'b1, E_DEC, 1'b0, "ST decode");
    add(T_LOAD,   1'b1, E_MA,  1'b0, "ST addr latched");
    add(T_LOAD,   1'b0, E_MW,  1'b0, "ST write wait");
    add(T_LOAD,   1'b1, E_MW,  1'b1, "ST write done");
    // BRANCH
    add(T_BRANCH, 1'b1, E_F1,  1'b0, "BR fetch");
    add(T_BRANCH, 1'b1, E_DEC, 1'b0, "BR decode");
    add(T_BRANCH, 1'b1, E_BR,  1'b1, "BR compare");

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl", 32'(act_vec), 32'(E_F0));
    chk("reset retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    step();

    // Table-driven sequence through the scoreboard
    exp_ret = '0;
    for (int i = 0; i < n_vec; i++) begin
      opcode    = vecs[i].op;
      mem_ready = vecs[i].mr;
      sb_q.push_back('{vecs[i].exp, exp_ret, vecs[i].name});
      if (vecs[i].ret) exp_ret = exp_ret + 1'b1;
      @(negedge clk);
      sb = sb_q.pop_front();
      chk({sb.name, " ctrl"}, 32'(act_vec), 32'(sb.exp));
      chk({sb.name, " retired"}, 32'(retired), 32'(sb.ret));
      $display("txn %0d %s ctrl=%h retired=%0d", i, sb.name, act_vec, retired);
      step();
    end

    // Unknown opcode
    opcode    = T_BAD;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bad fetch", 32'(act_vec), 32'(E_F1));
    step();
    @(negedge clk);
    chk("bad decode", 32'(act_vec), 32'(E_DEC));
    step();
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    @(negedge clk);
    chk("trap ctrl", 32'(act_vec), 32'(E_TRAP));
    chk("trap retired", 32'(retired), 32'(exp_ret));
    for (int k = 0; k < 4; k++) begin
      mem_ready = k[0];
      opcode    = T_R;
      step();
      @(negedge clk);
      chk("trap stuck", 32'(act_vec), 32'(E_TRAP));
    end
    $display("txn trap illegal=%0b retired=%0d", illegal, retired);
`else
    mem_ready = 1'b0;
    @(negedge clk);
    chk("nop back to fetch", 32'(act_vec), 32'(E_F0));
    chk("nop retired", 32'(retired), 32'(exp_ret + 1'b1));
    $display("txn nop ctrl=%h retired=%0d", act_vec, retired);
`endif

    // Reset from any state
    step();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk("reset2 ctrl", 32'(act_vec), 32'(E_F0));
    chk("reset2 retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Async reset in the middle of MEM_READ aborts the load
    run_branch();
    @(negedge clk);
    chk("pre-abort retired", 32'(retired), 32'd1);
    step();
    opcode    = T_LOAD;
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    step();
    #1;
    chk("mid mem_read ctrl", 32'(act_vec), 32'(E_MR));
    rst_n = 1'b0;
    #1;
    chk("abort ctrl", 32'(act_vec), 32'(E_F0));
    chk("abort retired", 32'(retired), 32'd0);
    $display("txn abort ctrl=%h retired=%0d", act_vec, retired);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post-abort ctrl", 32'(act_vec), 32'(E_F0));
    chk("post-abort retired", 32'(retired), 32'd0);

    // Counter wrap: 15 branches then one store
    step();
    for (int k = 0; k < 15; k++) run_branch();
    @(negedge clk);
    chk("retired all-ones", 32'(retired), 32'hF);
    opcode    = T_STORE;
    mem_ready = 1'b1;
    step();
    step();
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (mem_write) found = 1'b1;
    end
    chk("store reaches mem_write", 32'(found), 32'd1);
    step();
    @(negedge clk);
    chk("wrap retired", 32'(retired), 32'd0);
    chk("wrap back to fetch", 32'(act_vec), 32'(E_F1));
    $display("txn wrap ctrl=%h retired=%0d", act_vec, retired);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I-subset datapath.
- Produces the 2-bit ALU operation class that the ALU control decoder consumes, plus all other datapath enables.
- Sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK per instruction, waits on a memory ready handshake, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instruction[6:0] from instruction register
- mem_ready  in  1  memory completed current read/write this cycle
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if ALU zero (beq)
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load instruction register
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR to register file
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs1
- alu_src_b  out  2  0 = rs2, 1 = const 4, 2 = immediate
- alu_op  out  2  0 = add, 1 = subtract, 2 = decode funct (to ALU control)
- pc_source  out  2  0 = ALU result, 1 = ALUOut
- retired  out  CNT_W  instructions completed since reset
- illegal  out  1  illegal-opcode indication (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state = FETCH, retired = 0, illegal = 0. All outputs are Moore decodes of state. A reset mid-instruction aborts it; no retire.
- Default value of every control output is 0 unless listed for a state.
- Supported opcodes: R = 0110011, I-ALU = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011.
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_op = 0.
  - ir_write and pc_write = 1 only when mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - alu_src_a = 0, alu_src_b = 2, alu_op = 0 (branch target into ALUOut).
  - Next state: R → EXEC_R; I-ALU → EXEC_I; LOAD/STORE → MEM_ADDR; BRANCH → BRANCH; other → ILLEGAL handling.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = 2; → ALU_WB.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op = 2; → ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0; retire; → FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, alu_op = 0; LOAD → MEM_READ, STORE → MEM_WRITE. Uses opcode latched in DECODE, not the live input.
- MEM_READ: mem_read = 1, i_or_d = 1; wait for mem_ready; → MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1; retire; → FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1; wait for mem_ready; retire on mem_ready; → FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = 1, pc_write_cond = 1, pc_source = 1; retire; → FETCH.
- Memory handshake: mem_read/mem_write are held stable until the cycle mem_ready = 1. mem_ready outside a memory state is ignored.
- Cycle counts with mem_ready tied high: R/I = 4, LOAD = 5, STORE = 4, BRANCH = 3.
- retired increments by exactly 1 on each completion edge. It wraps from all-ones to 0 silently.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_TRAP_EN.
- Defined: unknown opcode in DECODE → TRAP state. TRAP sets illegal = 1, asserts no other controls, and stays in TRAP until reset.
- Undefined: unknown opcode → FETCH (treated as NOP, retire counted), and illegal is tied 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - ALU-op class enum (ADD/SUB/FUNCT), also consumed by the ALU control decoder
  - alu_src_b and pc_source encodings
  - state enum
- No sub-module; one FSM with registered state and latched opcode, combinational output decode.

Test Plan:
- rst_n low mid-MEM_READ → state FETCH, retired = 0, mem_read = 1 and i_or_d = 0 immediately (async).
- R-type 0110011, mem_ready = 1 → EXEC_R shows alu_op = 2, alu_src_b = 0; reg_write pulses one cycle; retired 0 → 1 after 4 cycles.
- LOAD with mem_ready low 3 cycles in MEM_READ → mem_read and i_or_d held 1 for 4 cycles, then MEM_WB reg_write = 1, mem_to_reg = 1; total 8 cycles.
- BRANCH 1100011 → state BRANCH with alu_op = 1, pc_write_cond = 1, pc_source = 1; returns to FETCH after 3 cycles.
- Opcode 1111111: with MULTICYCLE_CONTROL_TRAP_EN, illegal = 1 and the FSM is stuck until reset; without it, back in FETCH with retired + 1.
- Preload retired = all-ones (CNT_W = 4, 15 instructions) then one store → retired = 0.
